// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared mode/segment types, stage payload and FRAC-scaled constants for activation_pipe
package activation_pkg;

  typedef enum logic [1:0] {
    MODE_SIGMOID       = 2'd0,
    MODE_SIGMOID_DERIV = 2'd1,
    MODE_RELU          = 2'd2,
    MODE_LEAKY_RELU    = 2'd3
  } act_mode_t;

  typedef enum logic [1:0] {
    SEG_LOW  = 2'd0,
    SEG_MID  = 2'd1,
    SEG_HIGH = 2'd2,
    SEG_SAT  = 2'd3
  } seg_t;

  typedef struct packed {
    logic      valid;
    act_mode_t mode;
    logic      sign;
  } stage_ctrl_t;

  function automatic logic [63:0] c_one(input int frac);
    return 64'd1 << frac;
  endfunction

  function automatic logic [63:0] c_five(input int frac);
    return 64'd5 << frac;
  endfunction

  function automatic logic [63:0] c_2_375(input int frac);
    return 64'd19 << (frac - 3);
  endfunction

  function automatic logic [63:0] c_0_84375(input int frac);
    return 64'd27 << (frac - 5);
  endfunction

  function automatic logic [63:0] c_0_625(input int frac);
    return 64'd5 << (frac - 3);
  endfunction

  function automatic logic [63:0] c_half(input int frac);
    return 64'd1 << (frac - 1);
  endfunction

endpackage

// File: rtl/sigmoid_pwl_core.sv
// rtl/sigmoid_pwl_core.sv - two-stage piecewise-linear sigmoid (decode, then shift/add/fold/clamp)
module sigmoid_pwl_core #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] sig
);
  import activation_pkg::*;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(c_one(FRAC));
  localparam logic [WIDTH-1:0] FIVE     = WIDTH'(c_five(FRAC));
  localparam logic [WIDTH-1:0] C2_375   = WIDTH'(c_2_375(FRAC));
  localparam logic [WIDTH-1:0] C0_84375 = WIDTH'(c_0_84375(FRAC));
  localparam logic [WIDTH-1:0] C0_625   = WIDTH'(c_0_625(FRAC));
  localparam logic [WIDTH-1:0] HALF     = WIDTH'(c_half(FRAC));
  localparam logic [WIDTH-1:0] LSB      = WIDTH'(1);

  logic [WIDTH-1:0] abs_c, dec_a, sig_c;
  seg_t             seg_c, dec_seg;
  logic             dec_neg;

  // Most-negative x negates to itself; as unsigned it is above FIVE and saturates.
  always_comb begin
    abs_c = x[WIDTH-1] ? -x : x;
    if (abs_c >= FIVE)        seg_c = SEG_SAT;
    else if (abs_c >= C2_375) seg_c = SEG_HIGH;
    else if (abs_c >= ONE)    seg_c = SEG_MID;
    else                      seg_c = SEG_LOW;
  end

  always_comb begin
    case (dec_seg)
      SEG_SAT:  sig_c = ONE;
      SEG_HIGH: sig_c = (dec_a >> 5) + C0_84375;
      SEG_MID:  sig_c = (dec_a >> 3) + C0_625;
      default:  sig_c = (dec_a >> 2) + HALF;
    endcase
    if (dec_neg)
      sig_c = ONE - sig_c;
    if (sig_c == '0)
      sig_c = LSB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_a   <= '0;
      dec_seg <= SEG_LOW;
      dec_neg <= 1'b0;
      sig     <= '0;
    end else if (en) begin
      dec_a   <= abs_c;
      dec_seg <= seg_c;
      dec_neg <= x[WIDTH-1];
      sig     <= sig_c;
    end
  end

endmodule

// File: rtl/activation_pipe.sv
// rtl/activation_pipe.sv - pipelined activation unit with valid/ready; ACTIVATION_DERIV_EN adds the sigmoid-derivative multiplier
module activation_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  import activation_pkg::*;

  logic en;
  stage_ctrl_t st1_ctrl, st2_ctrl, st3_ctrl;
  logic [TAG_W-1:0] st1_tag, st2_tag, st3_tag;
  logic [WIDTH-1:0] st1_x, st2_x, st3_x;
  logic [WIDTH-1:0] sig, deriv_c, result_c;
  logic signed [WIDTH-1:0] leaky_c;

  // One global enable: a stalled output freezes every stage, bubbles included.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      st1_ctrl <= '0;
      st2_ctrl <= '0;
      st3_ctrl <= '0;
      st1_tag  <= '0;
      st2_tag  <= '0;
      st3_tag  <= '0;
      st1_x    <= '0;
      st2_x    <= '0;
      st3_x    <= '0;
    end else if (en) begin
      st1_ctrl <= '{valid: in_valid, mode: act_mode_t'(in_mode), sign: in_data[WIDTH-1]};
      st1_tag  <= in_tag;
      st1_x    <= in_data;
      st2_ctrl <= st1_ctrl;
      st2_tag  <= st1_tag;
      st2_x    <= st1_x;
      st3_ctrl <= st2_ctrl;
      st3_tag  <= st2_tag;
      st3_x    <= st2_x;
    end
  end

  sigmoid_pwl_core #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (st1_x),
    .sig (sig)
  );

`ifdef ACTIVATION_DERIV_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(c_one(FRAC));
  logic [2*WIDTH-1:0] prod_c;
  // s <= ONE, so the shifted product always fits in WIDTH bits.
  assign prod_c  = {{WIDTH{1'b0}}, sig} * {{WIDTH{1'b0}}, ONE - sig};
  assign deriv_c = WIDTH'(prod_c >> FRAC);
`else
  assign deriv_c = sig;
`endif

  assign leaky_c = $signed(st3_x) >>> 3;

  always_comb begin
    result_c = sig;
    case (st3_ctrl.mode)
      MODE_SIGMOID:       result_c = sig;
      MODE_SIGMOID_DERIV: result_c = deriv_c;
      MODE_RELU: begin
        if (st3_ctrl.sign) result_c = '0;
        else               result_c = st3_x;
      end
      MODE_LEAKY_RELU: begin
        if (st3_ctrl.sign) result_c = leaky_c;
        else               result_c = st3_x;
      end
      default:            result_c = sig;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= st3_ctrl.valid;
      out_data  <= result_c;
      out_tag   <= st3_tag;
    end
  end

endmodule
